// File: rtl/ws2812_encoder.sv
// ws2812_encoder
//
// Serialises 24-bit GRB pixels into the single-wire WS2812 NRZ waveform.
// One pixel is accepted per valid/ready handshake and shifted out MSB first.
// Each bit is TBIT cycles long and starts with a high phase of T1H cycles
// (for a 1) or T0H cycles (for a 0). When the pixel stream stops, a TRES-cycle
// low latch period is inserted automatically.
//
// Handshake: a pixel is transferred on every rising clk edge where
// pixel_valid && pixel_ready. pixel_data is sampled only on that edge.
// pixel_valid while pixel_ready is low has no effect. pixel_ready is high in
// IDLE and, while sending, only in the final cycle of bit 0. This gives
// zero-gap back-to-back pixels.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   pixel_data  in   [23:0] GRB pixel, bit 23 (G7) sent first
//   pixel_valid in   upstream offers a pixel
//   pixel_ready out  encoder accepts pixel_data this cycle (from state)
//   dout        out  registered WS2812 data line
//   busy        out  high while sending bits or holding the latch period
//
// The FSM state is held in the signal "state" (IDLE/SEND/LATCH). Checkers can
// bind to it.

module ws2812_encoder #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 63,
    parameter int TRES = 2600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        dout,
    output logic        busy
);

    localparam int CMAX = (TBIT > TRES) ? TBIT : TRES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRES_LAST = CW'(TRES - 1);
    localparam logic [CW-1:0] T0H_C     = CW'(T0H);
    localparam logic [CW-1:0] T1H_C     = CW'(T1H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state;
    logic [23:0]   shift_q;
    logic [4:0]    bit_idx;
    logic [CW-1:0] cnt;

    logic          bit_end;
    logic          pixel_end;
    logic          handshake;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] high_limit;

    assign bit_end    = (state == SEND) && (cnt == TBIT_LAST);
    assign pixel_end  = bit_end && (bit_idx == 5'd0);
    assign cnt_inc    = cnt + CW'(1);
    assign high_limit = shift_q[23] ? T1H_C : T0H_C;

    assign pixel_ready = (state == IDLE) || pixel_end;
    assign handshake   = pixel_valid && pixel_ready;
    assign busy        = (state != IDLE);

    // dout is registered. Its next value is derived from the counter value
    // the next cycle will have, so the line is high in the first cycle of
    // every bit. That cycle includes the one right after a handshake.
    // T0H >= 1 guarantees every bit starts high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            dout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    if (handshake) begin
                        shift_q <= pixel_data;
                        bit_idx <= 5'd23;
                        cnt     <= '0;
                        dout    <= 1'b1;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx != 5'd0) begin
                            shift_q <= {shift_q[22:0], 1'b0};
                            bit_idx <= bit_idx - 5'd1;
                            dout    <= 1'b1;
                        end else if (handshake) begin
                            // Back-to-back: next pixel starts with no gap.
                            shift_q <= pixel_data;
                            bit_idx <= 5'd23;
                            dout    <= 1'b1;
                        end else begin
                            dout  <= 1'b0;
                            state <= LATCH;
                        end
                    end else begin
                        cnt  <= cnt_inc;
                        dout <= (cnt_inc < high_limit);
                    end
                end

                LATCH: begin
                    dout <= 1'b0;
                    if (cnt == TRES_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    dout  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Testbench for ws2812_encoder.
//
// Two instances are used. dut_d has the default timing. dut_s has small
// timing (T0H=2, T1H=4, TBIT=6, TRES=10). "sel" chooses which instance
// receives pixel_valid and is observed.
//
// The expected line waveform is derived from the pixel values themselves.
// Every bit is a TBIT-cycle window whose first (bit ? T1H : T0H) samples are
// high. A stream of pixels is followed by TRES low/busy cycles and then idle.

module tb_ws2812_encoder;

    localparam int D_T0H = 20, D_T1H = 40, D_TBIT = 63, D_TRES = 2600;
    localparam int S_T0H = 2,  S_T1H = 4,  S_TBIT = 6,  S_TRES = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        sel;

    logic ready_d, dout_d, busy_d;
    logic ready_s, dout_s, busy_s;
    logic valid_d, valid_s;
    logic ready_m, dout_m, busy_m;

    assign valid_d = pixel_valid && !sel;
    assign valid_s = pixel_valid && sel;
    assign ready_m = sel ? ready_s : ready_d;
    assign dout_m  = sel ? dout_s  : dout_d;
    assign busy_m  = sel ? busy_s  : busy_d;

    ws2812_encoder dut_d (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_data  (pixel_data),
        .pixel_valid (valid_d),
        .pixel_ready (ready_d),
        .dout        (dout_d),
        .busy        (busy_d)
    );

    ws2812_encoder #(
        .T0H  (S_T0H),
        .T1H  (S_T1H),
        .TBIT (S_TBIT),
        .TRES (S_TRES)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_data  (pixel_data),
        .pixel_valid (valid_s),
        .pixel_ready (ready_s),
        .dout        (dout_s),
        .busy        (busy_s)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] px_q[$];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

    // ---------------- driver / checker tasks ----------------

    // Send all pixels in px_q as one stream and check the waveform.
    // When noise is set, pixel_valid and pixel_data are randomised in every
    // cycle where no handshake is intended. This includes the latch period.
    task automatic send_and_check(input string name, input bit noise);
        int          n, h, waited, rdy_cnt, busy_cnt, lat_ok;
        int          t0h, t1h, tbit, tres;
        logic [63:0] win, exp_win;

        t0h  = sel ? S_T0H  : D_T0H;
        t1h  = sel ? S_T1H  : D_T1H;
        tbit = sel ? S_TBIT : D_TBIT;
        tres = sel ? S_TRES : D_TRES;
        n    = px_q.size();

        pixel_data  = px_q[0];
        pixel_valid = 1'b1;
        waited = 0;
        while (!ready_m && waited < 10000) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (!ready_m) begin
            $display("FAIL %s initial_ready: got 0 after %0d cycles, want 1", name, waited);
            pixel_valid = 1'b0;
            return;
        end
        n_pass++;
        @(posedge clk); #1;

        rdy_cnt  = 0;
        busy_cnt = 0;
        for (int p = 0; p < n; p++) begin
            if (p + 1 < n) begin
                pixel_data  = px_q[p+1];
                pixel_valid = 1'b1;
            end else begin
                pixel_data  = 24'($urandom);
                pixel_valid = 1'b0;
            end
            for (int b = 23; b >= 0; b--) begin
                h       = px_q[p][b] ? t1h : t0h;
                win     = '0;
                exp_win = '0;
                for (int c = 0; c < tbit; c++) begin
                    win[c]     = dout_m;
                    exp_win[c] = (c < h);
                    if (ready_m) rdy_cnt++;
                    if (busy_m)  busy_cnt++;
                    if (b == 0 && c == tbit - 1) begin
                        if (p + 1 < n) begin
                            pixel_data  = px_q[p+1];
                            pixel_valid = 1'b1;
                        end else begin
                            pixel_valid = 1'b0;
                        end
                    end else if (noise) begin
                        pixel_valid = 1'($urandom_range(0, 1));
                        pixel_data  = 24'($urandom);
                    end
                    @(posedge clk); #1;
                end
                n_checks++;
                if (win !== exp_win)
                    $display("FAIL %s bit_window px%0d bit%0d: got %h want %h", name, p, b, win, exp_win);
                else
                    n_pass++;
            end
        end

        // pixel_ready pulses once per pixel, in the final cycle of bit 0.
        n_checks++;
        if (rdy_cnt !== n)
            $display("FAIL %s ready_pulses: got %0d want %0d", name, rdy_cnt, n);
        else
            n_pass++;

        n_checks++;
        if (busy_cnt !== n * 24 * tbit)
            $display("FAIL %s busy_send: got %0d want %0d", name, busy_cnt, n * 24 * tbit);
        else
            n_pass++;

        lat_ok = 0;
        for (int i = 0; i < tres; i++) begin
            if (dout_m === 1'b0 && busy_m === 1'b1 && ready_m === 1'b0) lat_ok++;
            if (i == tres - 1) begin
                pixel_valid = 1'b0;
            end else if (noise) begin
                pixel_valid = 1'($urandom_range(0, 1));
                pixel_data  = 24'($urandom);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (lat_ok !== tres)
            $display("FAIL %s latch_cycles: got %0d want %0d", name, lat_ok, tres);
        else
            n_pass++;

        n_checks++;
        if ({dout_m, busy_m, ready_m} !== 3'b001)
            $display("FAIL %s back_to_idle: got dout/busy/ready=%b want 001", name, {dout_m, busy_m, ready_m});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        int bad;
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        sel         = 1'b0;
        #23;
        n_checks++;
        if ({dout_d, busy_d, ready_d} !== 3'b001)
            $display("FAIL reset_default: got dout/busy/ready=%b want 001", {dout_d, busy_d, ready_d});
        else
            n_pass++;
        n_checks++;
        if ({dout_s, busy_s, ready_s} !== 3'b001)
            $display("FAIL reset_small: got dout/busy/ready=%b want 001", {dout_s, busy_s, ready_s});
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if ({dout_d, busy_d, ready_d, dout_s, busy_s, ready_s} !== 6'b001001) bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL reset_hold: got %0d bad cycles want 0", bad);
        else
            n_pass++;
    endtask

    task automatic test_single_pixel();
        sel = 1'b0;
        px_q.delete();
        px_q.push_back(24'hFF0000);
        send_and_check("single_ff0000", 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        px_q.delete();
        px_q.push_back(24'hAAAAAA);
        px_q.push_back(24'h555555);
        send_and_check("b2b_aa_55", 1'b0);
    endtask

    task automatic test_handshake_rules();
        sel = 1'b0;
        px_q.delete();
        px_q.push_back(24'h00FF0F);
        px_q.push_back(24'hC3A55A);
        send_and_check("handshake_noise", 1'b1);
    endtask

    task automatic test_random();
        sel = 1'b0;
        px_q.delete();
        for (int i = 0; i < 3; i++) px_q.push_back(24'($urandom));
        send_and_check("random_stream", 1'b1);
    endtask

    task automatic test_async_reset();
        int bad, waited;
        sel         = 1'b0;
        pixel_data  = 24'hFFFFFF;
        pixel_valid = 1'b1;
        waited = 0;
        while (!ready_d && waited < 10000) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (dout_d !== 1'b1)
            $display("FAIL async_pre_high: got dout=%b want 1", dout_d);
        else
            n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dout_d, busy_d, ready_d} !== 3'b001)
            $display("FAIL async_reset_now: got dout/busy/ready=%b want 001", {dout_d, busy_d, ready_d});
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < D_TRES + 100; i++) begin
            @(posedge clk); #1;
            if ({dout_d, busy_d, ready_d} !== 3'b001) bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL async_no_latch: got %0d non-idle cycles want 0", bad);
        else
            n_pass++;
    endtask

    task automatic test_small_params();
        sel = 1'b1;
        px_q.delete();
        px_q.push_back(24'h800001);
        send_and_check("small_800001", 1'b0);
        px_q.delete();
        px_q.push_back(24'($urandom));
        px_q.push_back(24'($urandom));
        send_and_check("small_random", 1'b1);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_handshake_rules();
        test_async_reset();
        test_random();
        test_small_params();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
